unidade_controle_jogo: RTL and testbench
========================================

Name: unidade_controle_jogo

Overview:
- Moore control FSM for the Jogão da Velha (ultimate tic-tac-toe) datapath.
- Sequences every move: macro-board choice, micro-cell choice, a RAM read wait, and the decision. Also tracks the current player.
- Sits directly upstream of the datapath. It drives the datapath's clear, load and mux-select lines and consumes its tem_jogada, escolhe_macro and fim_jogo status.

Parameters:
- TIMEOUT_CICLOS, 5000, clock cycles allowed per move in a wait state (used only with TIMEOUT_EN).
- LARGURA_TIMEOUT, 13, width of the timeout counter; must satisfy 2^LARGURA_TIMEOUT > TIMEOUT_CICLOS.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; forces state INICIAL.
- iniciar  in  1  start/restart request (level, sampled each cycle).
- tem_jogada  in  1  one-cycle pulse from the datapath edge detector: a button was pressed.
- escolhe_macro  in  1  the current micro target board is already decided; the next player picks a free macro board.
- fim_jogo  in  1  the game has ended (win or draw).
- zeraEdge  out  1  clears the edge detector.
- zeraR_micro  out  1  clears the micro register.
- zeraR_macro  out  1  clears the macro register.
- registraR_micro  out  1  loads the micro register from the buttons.
- registraR_macro  out  1  loads the macro register.
- sinal_macro  out  1  macro mux select: 1 = buttons, 0 = micro register.
- jogador  out  1  current player: 0 = X, 1 = O.
- pronto  out  1  game finished; held while in FIM.
- timeout  out  1  game ended by timeout (constant 0 without TIMEOUT_EN).
- db_estado  out  4  current state encoding, for debug.

Behaviour:
- Single always block for the state register, clocked on clock. Reset is synchronous and active-high: state <= INICIAL, jogador <= 0, timeout counter <= 0.
- All control outputs are pure Moore decodes of the state. Any output not listed for a state is 0.
- State encodings, outputs and transitions:
  - INICIAL (4'h0): all outputs 0. If iniciar=1, go to PREPARACAO.
  - PREPARACAO (4'h1): zeraEdge=1, zeraR_micro=1, zeraR_macro=1; jogador <= 0. Unconditionally go to ESPERA_MACRO.
  - ESPERA_MACRO (4'h2): if tem_jogada=1, go to REGISTRA_MACRO; otherwise stay.
  - REGISTRA_MACRO (4'h3): sinal_macro=1, registraR_macro=1. Go to ESPERA_MICRO.
  - ESPERA_MICRO (4'h4): if tem_jogada=1, go to REGISTRA_MICRO; otherwise stay.
  - REGISTRA_MICRO (4'h5): registraR_micro=1. Go to ESPERA_RAM.
  - ESPERA_RAM (4'h6): one cycle to absorb the synchronous-read latency of the board-state RAM. Go to DECIDE.
  - DECIDE (4'h7), evaluated in priority order:
    - fim_jogo=1: go to FIM; jogador is not toggled.
    - else escolhe_macro=1: toggle jogador, go to ESPERA_MACRO.
    - else: toggle jogador, go to ATUALIZA_MACRO.
  - ATUALIZA_MACRO (4'h8): sinal_macro=0, registraR_macro=1 (macro <= micro). Go to ESPERA_MICRO.
  - FIM (4'hF): pronto=1. If iniciar=1, go to PREPARACAO; otherwise stay.
  - Any other encoding: go to INICIAL.
- Move latency: from a tem_jogada pulse in ESPERA_MICRO, DECIDE is reached 3 cycles later.
- tem_jogada arriving in any state other than ESPERA_MACRO or ESPERA_MICRO is ignored and not queued.
- Simultaneous iniciar and tem_jogada in FIM: iniciar wins.
- iniciar is ignored in every state except INICIAL and FIM.
- reset asserted mid-move overrides all transitions in that cycle. pronto and timeout read 0 in the following cycle.
- db_estado always equals the state encoding.

Optional Feature:
- Macro: JOGADA_TIMEOUT_EN.
- When defined:
  - A counter increments every cycle spent in ESPERA_MACRO or ESPERA_MICRO.
  - The counter clears on entering either wait state, in PREPARACAO, and on reset.
  - When the counter equals TIMEOUT_CICLOS-1 and tem_jogada=0, go to FIM and set a timeout flag. If tem_jogada=1 in that same cycle, the move wins.
  - The timeout flag is cleared in PREPARACAO and on reset; the timeout output reflects it.
  - jogador is not toggled on timeout, so it identifies the player who timed out.
- When undefined: no counter is built, timeout is tied to 0, and LARGURA_TIMEOUT and TIMEOUT_CICLOS are unused.

Decomposition:
- Shared package jogo_pkg holds:
  - the 4-bit state localparams (INICIAL … FIM);
  - the player constants JOGADOR_X=1'b0 and JOGADOR_O=1'b1.
- One sub-module is natural: contador_timeout (enable, clear, terminal-count output), instantiated only under JOGADA_TIMEOUT_EN.

Test Plan:
1. reset=1 for 2 cycles → db_estado=0, all control outputs 0, pronto=0, jogador=0. Then iniciar=1 → next cycle db_estado=1 with the three clear outputs=1; the cycle after, db_estado=2.
2. From ESPERA_MACRO, pulse tem_jogada; later pulse tem_jogada in ESPERA_MICRO, with escolhe_macro=0 and fim_jogo=0 → state sequence 3,4,5,6,7,8,4. sinal_macro=1 only in state 3; registraR_macro=1 in states 3 and 8; jogador goes 0→1 after DECIDE.
3. Same flow with escolhe_macro=1 in DECIDE → return to state 2 with jogador toggled. A second full move returns jogador to 0.
4. fim_jogo=1 in DECIDE → state F, pronto=1, jogador unchanged. Then iniciar=1 with tem_jogada=1 in the same cycle → state 1, then state 2 with jogador=0.
5. tem_jogada pulses while in states 5, 6 and 7 → ignored; the FSM sits in ESPERA_MICRO until a fresh pulse arrives.
6. With JOGADA_TIMEOUT_EN and TIMEOUT_CICLOS=8, no press → exactly 8 cycles in state 4, then F with timeout=1 and pronto=1. Repeat with a press on cycle 8 → REGISTRA_MICRO is taken and timeout stays 0.

Source files
------------

// File: rtl/jogo_pkg.sv
// rtl/jogo_pkg.sv - shared state encodings and player constants for the game control unit
package jogo_pkg;

    localparam logic [3:0] INICIAL        = 4'h0;
    localparam logic [3:0] PREPARACAO     = 4'h1;
    localparam logic [3:0] ESPERA_MACRO   = 4'h2;
    localparam logic [3:0] REGISTRA_MACRO = 4'h3;
    localparam logic [3:0] ESPERA_MICRO   = 4'h4;
    localparam logic [3:0] REGISTRA_MICRO = 4'h5;
    localparam logic [3:0] ESPERA_RAM     = 4'h6;
    localparam logic [3:0] DECIDE         = 4'h7;
    localparam logic [3:0] ATUALIZA_MACRO = 4'h8;
    localparam logic [3:0] FIM            = 4'hF;

    localparam logic JOGADOR_X = 1'b0;
    localparam logic JOGADOR_O = 1'b1;

    // True for the two states where the FSM waits for a button press.
    function automatic logic eh_espera(input logic [3:0] estado);
        return (estado == ESPERA_MACRO) || (estado == ESPERA_MICRO);
    endfunction

endpackage

// File: rtl/contador_timeout.sv
// rtl/contador_timeout.sv - per-move wait counter with terminal-count flag
//
// Ports:
//   clock      - system clock
//   reset      - synchronous, active-high clear
//   limpa_i    - synchronous clear (priority over habilita_i)
//   habilita_i - count enable
//   terminal_o - high while the count equals CICLOS-1
module contador_timeout #(
    parameter int LARGURA = 13,
    parameter int CICLOS  = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic limpa_i,
    input  logic habilita_i,
    output logic terminal_o
);

    logic [LARGURA-1:0] contagem_q;

    always_ff @(posedge clock) begin
        if (reset || limpa_i) begin
            contagem_q <= '0;
        end else if (habilita_i) begin
            contagem_q <= contagem_q + 1'b1;
        end
    end

    assign terminal_o = (contagem_q == LARGURA'(CICLOS - 1));

endmodule

// File: rtl/unidade_controle_jogo.sv
// rtl/unidade_controle_jogo.sv - Moore control FSM sequencing each ultimate tic-tac-toe move
//
// Optional move timeout enabled by defining JOGADA_TIMEOUT_EN.
//
// Ports:
//   clock, reset        - clock and synchronous active-high reset
//   iniciar             - start/restart request (honoured in INICIAL and FIM)
//   tem_jogada          - one-cycle button-press pulse from the datapath
//   escolhe_macro       - next player picks a free macro board
//   fim_jogo            - game over (win or draw)
//   zeraEdge, zeraR_micro, zeraR_macro - datapath clears
//   registraR_micro, registraR_macro   - datapath register loads
//   sinal_macro         - macro mux select (1 = buttons, 0 = micro register)
//   jogador             - current player (0 = X, 1 = O)
//   pronto              - game finished
//   timeout             - game ended by move timeout
//   db_estado           - current state encoding
module unidade_controle_jogo
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CICLOS  = 5000,
    parameter int LARGURA_TIMEOUT = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       tem_jogada,
    input  logic       escolhe_macro,
    input  logic       fim_jogo,
    output logic       zeraEdge,
    output logic       zeraR_micro,
    output logic       zeraR_macro,
    output logic       registraR_micro,
    output logic       registraR_macro,
    output logic       sinal_macro,
    output logic       jogador,
    output logic       pronto,
    output logic       timeout,
    output logic [3:0] db_estado
);

    logic [3:0] estado_q, estado_d;
    logic       jogador_q, jogador_d;
    logic       expirou;

    // Guard block: the timeout counter must be able to reach TIMEOUT_CICLOS-1.
    if (TIMEOUT_CICLOS < 1 || (64'd1 << LARGURA_TIMEOUT) <= 64'(TIMEOUT_CICLOS)) begin : g_parametros_invalidos
    end

`ifdef JOGADA_TIMEOUT_EN
    logic timeout_q, timeout_d;
    logic terminal;
    logic limpa_contador;

    // Clear on every entry into a wait state so each wait gets a full budget.
    assign limpa_contador = (estado_q == PREPARACAO) ||
                            (eh_espera(estado_d) && (estado_d != estado_q));

    contador_timeout #(
        .LARGURA (LARGURA_TIMEOUT),
        .CICLOS  (TIMEOUT_CICLOS)
    ) u_contador_timeout (
        .clock      (clock),
        .reset      (reset),
        .limpa_i    (limpa_contador),
        .habilita_i (eh_espera(estado_q)),
        .terminal_o (terminal)
    );

    // A press in the terminal cycle beats the timeout.
    assign expirou = terminal && !tem_jogada;
    assign timeout = timeout_q;
`else
    assign expirou = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= INICIAL;
            jogador_q <= JOGADOR_X;
`ifdef JOGADA_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            jogador_q <= jogador_d;
`ifdef JOGADA_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        estado_d  = estado_q;
        jogador_d = jogador_q;
`ifdef JOGADA_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                jogador_d = JOGADOR_X;
`ifdef JOGADA_TIMEOUT_EN
                timeout_d = 1'b0;
`endif
                estado_d  = ESPERA_MACRO;
            end
            ESPERA_MACRO: begin
                if (tem_jogada) begin
                    estado_d = REGISTRA_MACRO;
                end else if (expirou) begin
                    estado_d = FIM;
`ifdef JOGADA_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end
            end
            REGISTRA_MACRO: estado_d = ESPERA_MICRO;
            ESPERA_MICRO: begin
                if (tem_jogada) begin
                    estado_d = REGISTRA_MICRO;
                end else if (expirou) begin
                    estado_d = FIM;
`ifdef JOGADA_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end
            end
            REGISTRA_MICRO: estado_d = ESPERA_RAM;
            ESPERA_RAM:     estado_d = DECIDE;
            DECIDE: begin
                // Winner keeps the turn so jogador names who ended the game.
                if (fim_jogo) begin
                    estado_d = FIM;
                end else begin
                    jogador_d = (jogador_q == JOGADOR_X) ? JOGADOR_O : JOGADOR_X;
                    estado_d  = escolhe_macro ? ESPERA_MACRO : ATUALIZA_MACRO;
                end
            end
            ATUALIZA_MACRO: estado_d = ESPERA_MICRO;
            FIM: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            default: estado_d = INICIAL;
        endcase
    end

    // Moore output decode
    always_comb begin
        zeraEdge        = 1'b0;
        zeraR_micro     = 1'b0;
        zeraR_macro     = 1'b0;
        registraR_micro = 1'b0;
        registraR_macro = 1'b0;
        sinal_macro     = 1'b0;
        pronto          = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zeraEdge    = 1'b1;
                zeraR_micro = 1'b1;
                zeraR_macro = 1'b1;
            end
            REGISTRA_MACRO: begin
                sinal_macro     = 1'b1;
                registraR_macro = 1'b1;
            end
            REGISTRA_MICRO: registraR_micro = 1'b1;
            // Next target board is the cell just played: macro <= micro.
            ATUALIZA_MACRO: registraR_macro = 1'b1;
            FIM:            pronto = 1'b1;
            default: ;
        endcase
    end

    assign jogador   = jogador_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb/tb_unidade_controle_jogo.sv - directed self-checking bench for unidade_controle_jogo
module tb_unidade_controle_jogo;

    logic       clock = 1'b0;
    logic       reset, iniciar, tem_jogada, escolhe_macro, fim_jogo;
    logic       zeraEdge, zeraR_micro, zeraR_macro, registraR_micro, registraR_macro;
    logic       sinal_macro, jogador, pronto, timeout;
    logic [3:0] db_estado;

    int n_assert = 0;
    int n_falhas = 0;

    unidade_controle_jogo #(
        .TIMEOUT_CICLOS  (8),
        .LARGURA_TIMEOUT (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .iniciar         (iniciar),
        .tem_jogada      (tem_jogada),
        .escolhe_macro   (escolhe_macro),
        .fim_jogo        (fim_jogo),
        .zeraEdge        (zeraEdge),
        .zeraR_micro     (zeraR_micro),
        .zeraR_macro     (zeraR_macro),
        .registraR_micro (registraR_micro),
        .registraR_macro (registraR_macro),
        .sinal_macro     (sinal_macro),
        .jogador         (jogador),
        .pronto          (pronto),
        .timeout         (timeout),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
        n_assert++;
        if (obtido !== esperado) begin
            n_falhas++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obtido, esperado);
        end
    endtask

    // Expected {zeraEdge, zeraR_micro, zeraR_macro, registraR_micro, registraR_macro, sinal_macro, pronto}
    function automatic logic [6:0] controle_esperado(input logic [3:0] estado);
        case (estado)
            4'h1:    return 7'b1110000;
            4'h3:    return 7'b0000110;
            4'h5:    return 7'b0001000;
            4'h8:    return 7'b0000100;
            4'hF:    return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic passo();
        @(posedge clock);
        #1;
    endtask

    task automatic confere(input string tag, input logic [3:0] estado, input logic jog, input logic tmo);
        logic [11:0] obtido, esperado;
        obtido   = {db_estado, zeraEdge, zeraR_micro, zeraR_macro, registraR_micro,
                    registraR_macro, sinal_macro, pronto, jogador};
        esperado = {estado, controle_esperado(estado), jog};
        verifica(tag, {20'd0, obtido}, {20'd0, esperado});
        verifica({tag, "_timeout"}, {31'd0, timeout}, {31'd0, tmo});
    endtask

    // One move from ESPERA_MICRO through DECIDE; ends after the DECIDE edge.
    task automatic jogada_micro(input string tag, input logic esc, input logic fim, input logic jog_antes);
        tem_jogada = 1'b1; passo(); tem_jogada = 1'b0;
        confere({tag, "_s5"}, 4'h5, jog_antes, 1'b0);
        escolhe_macro = esc; fim_jogo = fim;
        passo(); confere({tag, "_s6"}, 4'h6, jog_antes, 1'b0);
        passo(); confere({tag, "_s7"}, 4'h7, jog_antes, 1'b0);
        passo();
        escolhe_macro = 1'b0; fim_jogo = 1'b0;
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; tem_jogada = 1'b0; escolhe_macro = 1'b0; fim_jogo = 1'b0;

        // 1: reset and start
        passo(); passo();
        confere("reset", 4'h0, 1'b0, 1'b0);
        reset = 1'b0; iniciar = 1'b1;
        passo(); confere("prep", 4'h1, 1'b0, 1'b0);
        iniciar = 1'b0;
        passo(); confere("esp_macro", 4'h2, 1'b0, 1'b0);

        // iniciar ignored outside INICIAL/FIM
        iniciar = 1'b1;
        passo(); confere("iniciar_ign", 4'h2, 1'b0, 1'b0);
        iniciar = 1'b0;

        // 2: full move with macro update
        tem_jogada = 1'b1; passo(); tem_jogada = 1'b0;
        confere("reg_macro", 4'h3, 1'b0, 1'b0);
        passo(); confere("esp_micro", 4'h4, 1'b0, 1'b0);
        passo(); confere("esp_micro_hold", 4'h4, 1'b0, 1'b0);
        jogada_micro("m1", 1'b0, 1'b0, 1'b0);
        confere("atualiza", 4'h8, 1'b1, 1'b0);
        passo(); confere("volta_micro", 4'h4, 1'b1, 1'b0);

        // 3: escolhe_macro returns to ESPERA_MACRO with toggled player
        jogada_micro("m2", 1'b1, 1'b0, 1'b1);
        confere("esc_macro", 4'h2, 1'b0, 1'b0);
        tem_jogada = 1'b1; passo(); tem_jogada = 1'b0;
        passo(); confere("m3_micro", 4'h4, 1'b0, 1'b0);
        jogada_micro("m3", 1'b1, 1'b0, 1'b0);
        confere("m3_fim", 4'h2, 1'b1, 1'b0);
        tem_jogada = 1'b1; passo(); tem_jogada = 1'b0;
        passo();
        jogada_micro("m4", 1'b1, 1'b0, 1'b1);
        confere("m4_fim", 4'h2, 1'b0, 1'b0);

        // 5: presses during 5, 6, 7 are ignored
        tem_jogada = 1'b1; passo(); tem_jogada = 1'b0;
        passo(); confere("m5_micro", 4'h4, 1'b0, 1'b0);
        tem_jogada = 1'b1;
        passo(); confere("ign_s5", 4'h5, 1'b0, 1'b0);
        passo(); confere("ign_s6", 4'h6, 1'b0, 1'b0);
        passo(); confere("ign_s7", 4'h7, 1'b0, 1'b0);
        tem_jogada = 1'b0;
        passo(); confere("ign_s8", 4'h8, 1'b1, 1'b0);
        passo(); passo(); passo();
        confere("ign_espera", 4'h4, 1'b1, 1'b0);

        // 4: game over, restart with simultaneous press
        jogada_micro("m6", 1'b0, 1'b1, 1'b1);
        confere("fim", 4'hF, 1'b1, 1'b0);
        passo(); confere("fim_hold", 4'hF, 1'b1, 1'b0);
        iniciar = 1'b1; tem_jogada = 1'b1;
        passo(); confere("reinicia", 4'h1, 1'b1, 1'b0);
        iniciar = 1'b0; tem_jogada = 1'b0;
        passo(); confere("reinicia_esp", 4'h2, 1'b0, 1'b0);

        // reset mid-move
        tem_jogada = 1'b1; passo(); tem_jogada = 1'b0;
        passo(); reset = 1'b1;
        passo(); reset = 1'b0;
        confere("reset_meio", 4'h0, 1'b0, 1'b0);
        iniciar = 1'b1; passo(); iniciar = 1'b0; passo();
        tem_jogada = 1'b1; passo(); tem_jogada = 1'b0;
        passo(); confere("t_entra", 4'h4, 1'b0, 1'b0);

`ifdef JOGADA_TIMEOUT_EN
        // 6: exactly 8 cycles in ESPERA_MICRO, then timeout
        for (int i = 2; i <= 8; i++) begin
            passo(); confere($sformatf("t_ciclo%0d", i), 4'h4, 1'b0, 1'b0);
        end
        passo(); confere("t_expira", 4'hF, 1'b0, 1'b1);
        iniciar = 1'b1; passo(); iniciar = 1'b0;
        confere("t_prep", 4'h1, 1'b0, 1'b0);
        passo();
        tem_jogada = 1'b1; passo(); tem_jogada = 1'b0;
        passo(); confere("t2_entra", 4'h4, 1'b0, 1'b0);
        for (int i = 2; i <= 7; i++) passo();
        passo();
        confere("t2_ciclo8", 4'h4, 1'b0, 1'b0);
        tem_jogada = 1'b1; passo(); tem_jogada = 1'b0;
        confere("t2_jogada", 4'h5, 1'b0, 1'b0);
`else
        // Without the timeout feature the FSM waits indefinitely.
        for (int i = 0; i < 20; i++) passo();
        confere("sem_timeout", 4'h4, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_falhas);
        $finish;
    end

endmodule
